// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment scan: synchronises the
// anode/cathode pins, rebuilds the digit patterns and checks scan order and liveness.
module seg_scan_capture #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1000000,
   parameter int TO_W    = 20
) (
   input  logic       clock_100Mhz,
   input  logic       reset,
   input  logic [3:0] Anode_Activate,
   input  logic [6:0] LED_out,
   output logic [6:0] digit0,
   output logic [6:0] digit1,
   output logic [6:0] digit2,
   output logic [6:0] digit3,
   output logic       frame_done,
   output logic       scan_err,
   output logic       scan_valid
);

   localparam int               ST_W    = $clog2(SETTLE + 1);
   localparam logic [ST_W-1:0]  ST_FIRE = ST_W'(SETTLE - 1);
   localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(SETTLE);
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);

   typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

   logic [3:0]      an_s1_q, an_s2_q, an_prev_q;
   logic [6:0]      cat_s1_q, cat_s2_q, cat_prev_q;
   logic [ST_W-1:0] stab_q, stab_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [6:0]      dig_q [4];
   state_t          state_q;
   logic [1:0]      expect_q, last_q;
   logic            frame_q, err_q, valid_q;

   logic            legal_s, illegal_s, same_s, an_new_s, fire_s, timeout_s;
   logic [1:0]      idx_s;

   // Anode decode: one-hot-low is a digit, all-high is blank, anything else is illegal.
   always_comb begin
      legal_s   = 1'b0;
      illegal_s = 1'b0;
      idx_s     = 2'd0;
      case (an_s2_q)
         4'b0111: begin legal_s = 1'b1; idx_s = 2'd0; end
         4'b1011: begin legal_s = 1'b1; idx_s = 2'd1; end
         4'b1101: begin legal_s = 1'b1; idx_s = 2'd2; end
         4'b1110: begin legal_s = 1'b1; idx_s = 2'd3; end
         4'b1111: begin legal_s = 1'b0; idx_s = 2'd0; end
         default: illegal_s = 1'b1;
      endcase
   end

   assign same_s   = (an_s2_q == an_prev_q) && (cat_s2_q == cat_prev_q);
   assign an_new_s = (an_s2_q != an_prev_q);

   // Settle and timeout counters; saturation past SETTLE-1 keeps capture one-shot per dwell.
   always_comb begin
      if (!legal_s) begin
         stab_d = '0;
      end else if (!same_s) begin
         stab_d = '0;
      end else if (stab_q != ST_MAX) begin
         stab_d = stab_q + 1'b1;
      end else begin
         stab_d = stab_q;
      end

      fire_s = legal_s && (stab_d == ST_FIRE) && ((stab_d != stab_q) || !same_s);

      if (fire_s) begin
         to_d = '0;
      end else if (to_q != TO_LIM) begin
         to_d = to_q + 1'b1;
      end else begin
         to_d = to_q;
      end

      timeout_s = (to_q == TO_LIM) && !fire_s;
   end

   // Input synchronisers, change tracking, counters and digit capture.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         an_s1_q    <= 4'hF;
         an_s2_q    <= 4'hF;
         an_prev_q  <= 4'hF;
         cat_s1_q   <= 7'h7F;
         cat_s2_q   <= 7'h7F;
         cat_prev_q <= 7'h7F;
         stab_q     <= '0;
         to_q       <= '0;
         for (int i = 0; i < 4; i++) begin
            dig_q[i] <= 7'h00;
         end
      end else begin
         an_s1_q    <= Anode_Activate;
         an_s2_q    <= an_s1_q;
         an_prev_q  <= an_s2_q;
         cat_s1_q   <= LED_out;
         cat_s2_q   <= cat_s1_q;
         cat_prev_q <= cat_s2_q;
         stab_q     <= stab_d;
         to_q       <= to_d;
         if (fire_s) begin
            dig_q[idx_s] <= ~cat_s2_q;
         end else begin
            dig_q[idx_s] <= dig_q[idx_s];
         end
      end
   end

   // Scan-order FSM with registered status; an illegal anode outranks any capture.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_q  <= HUNT;
         expect_q <= 2'd0;
         last_q   <= 2'd0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         err_q   <= 1'b0;
         if (illegal_s) begin
            state_q <= HUNT;
            if (an_new_s) begin
               err_q   <= 1'b1;
               valid_q <= 1'b0;
            end else begin
               valid_q <= valid_q;
            end
         end else if (fire_s) begin
            last_q <= idx_s;
            case (state_q)
               HUNT: begin
                  if (idx_s == 2'd0) begin
                     state_q  <= TRACK;
                     expect_q <= 2'd1;
                  end else begin
                     state_q  <= HUNT;
                  end
               end
               TRACK: begin
                  if (idx_s == expect_q) begin
                     expect_q <= expect_q + 2'd1;
                     if (idx_s == 2'd3) begin
                        frame_q <= 1'b1;
                        valid_q <= 1'b1;
                     end else begin
                        frame_q <= 1'b0;
                     end
                  end else if (idx_s != last_q) begin
                     err_q   <= 1'b1;
                     valid_q <= 1'b0;
                     if (idx_s == 2'd0) begin
                        state_q  <= TRACK;
                        expect_q <= 2'd1;
                     end else begin
                        state_q  <= HUNT;
                     end
                  end else begin
                     state_q <= TRACK;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end else if (timeout_s) begin
            valid_q <= 1'b0;
            state_q <= HUNT;
         end else begin
            state_q <= state_q;
         end
      end
   end

   assign digit0     = dig_q[0];
   assign digit1     = dig_q[1];
   assign digit2     = dig_q[2];
   assign digit3     = dig_q[3];
   assign frame_done = frame_q;
   assign scan_err   = err_q;
   assign scan_valid = valid_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scan order, settling, illegal anodes, reset and timeout.
module tb_seg_scan_capture;

   localparam int TO = 200;

   localparam logic [6:0] C0 = 7'b0000001;
   localparam logic [6:0] C1 = 7'b1001111;
   localparam logic [6:0] C2 = 7'b0010010;
   localparam logic [6:0] C3 = 7'b0000110;
   localparam logic [6:0] C8 = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] an  = 4'b1111;
   logic [6:0] cat = 7'h7F;
   logic [6:0] d0, d1, d2, d3;
   logic       fd, se, sv;

   int n_chk  = 0;
   int n_fail = 0;
   int fd_cnt = 0;
   int err_cnt = 0;

   seg_scan_capture #(.SETTLE(4), .TIMEOUT(TO), .TO_W(8)) dut (
      .clock_100Mhz   (clk),
      .reset          (rst),
      .Anode_Activate (an),
      .LED_out        (cat),
      .digit0         (d0),
      .digit1         (d1),
      .digit2         (d2),
      .digit3         (d3),
      .frame_done     (fd),
      .scan_err       (se),
      .scan_valid     (sv)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fd === 1'b1) fd_cnt = fd_cnt + 1;
      if (se === 1'b1) err_cnt = err_cnt + 1;
   end

   function automatic logic [3:0] anode_of(input int idx);
      logic [3:0] a;
      case (idx)
         0: a = 4'b0111;
         1: a = 4'b1011;
         2: a = 4'b1101;
         default: a = 4'b1110;
      endcase
      return a;
   endfunction

   task automatic dwell(input logic [3:0] a, input logic [6:0] c, input int n);
      an  = a;
      cat = c;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      dwell(anode_of(0), C0, 16);
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(2), C2, 16);
      dwell(anode_of(3), C3, 16);
   endtask

   task automatic test_reset();
      int e0;
      @(negedge clk);
      n_chk++; if ({d0, d1, d2, d3} !== 28'h0) begin n_fail++; $display("FAIL reset_digits got %h exp 0", {d0, d1, d2, d3}); end
      n_chk++; if ({fd, se, sv} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {fd, se, sv}); end
      rst = 1'b0;
      e0 = err_cnt;
      repeat (TO + 50) @(negedge clk);
      n_chk++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL idle_err got %0d exp 0", err_cnt - e0); end
      n_chk++; if (sv !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", sv); end
      n_chk++; if ({d0, d1, d2, d3} !== 28'h0) begin n_fail++; $display("FAIL idle_digits got %h exp 0", {d0, d1, d2, d3}); end
   endtask

   task automatic test_clean_scan();
      int f0, e0;
      f0 = fd_cnt; e0 = err_cnt;
      dwell(anode_of(0), C0, 16);
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(2), C2, 16);
      an = anode_of(3); cat = C3;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 5) begin
            n_chk++; if ({fd, sv} !== 2'b00) begin n_fail++; $display("FAIL clean_pre_edge got %b exp 00", {fd, sv}); end
            n_chk++; if (d3 !== 7'h00) begin n_fail++; $display("FAIL clean_d3_early got %h exp 00", d3); end
         end
         if (i == 6) begin
            n_chk++; if ({fd, sv} !== 2'b11) begin n_fail++; $display("FAIL clean_edge got %b exp 11", {fd, sv}); end
         end
         if (i == 7) begin
            n_chk++; if (fd !== 1'b0) begin n_fail++; $display("FAIL clean_pulse_width got %b exp 0", fd); end
         end
      end
      n_chk++; if ({d0, d1, d2, d3} !== {7'h7E, 7'h30, 7'h6D, 7'h79}) begin n_fail++; $display("FAIL clean_digits got %h exp %h", {d0, d1, d2, d3}, {7'h7E, 7'h30, 7'h6D, 7'h79}); end
      n_chk++; if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL clean_frames got %0d exp 1", fd_cnt - f0); end
      n_chk++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL clean_err got %0d exp 0", err_cnt - e0); end
   endtask

   task automatic test_out_of_order();
      int f0, e0;
      f0 = fd_cnt; e0 = err_cnt;
      dwell(anode_of(0), C0, 16);
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(3), C8, 16);
      n_chk++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ooo_err got %0d exp 1", err_cnt - e0); end
      n_chk++; if (sv !== 1'b0) begin n_fail++; $display("FAIL ooo_valid got %b exp 0", sv); end
      n_chk++; if (d3 !== 7'h7F) begin n_fail++; $display("FAIL ooo_d3 got %h exp 7f", d3); end
      n_chk++; if (fd_cnt - f0 !== 0) begin n_fail++; $display("FAIL ooo_frames got %0d exp 0", fd_cnt - f0); end
      frame();
      n_chk++; if ({sv, d3} !== {1'b1, 7'h79}) begin n_fail++; $display("FAIL ooo_recover got %h exp %h", {sv, d3}, {1'b1, 7'h79}); end
      n_chk++; if (fd_cnt - f0 !== 1 || err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ooo_recover_counts got fd=%0d err=%0d exp fd=1 err=1", fd_cnt - f0, err_cnt - e0); end
   endtask

   task automatic test_illegal();
      int f0, e0;
      f0 = fd_cnt; e0 = err_cnt;
      dwell(anode_of(0), C0, 16);
      dwell(anode_of(1), C1, 16);
      dwell(4'b0011, C8, 8);
      n_chk++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL illegal_err got %0d exp 1", err_cnt - e0); end
      n_chk++; if (sv !== 1'b0) begin n_fail++; $display("FAIL illegal_valid got %b exp 0", sv); end
      n_chk++; if ({d0, d1, d2, d3} !== {7'h7E, 7'h30, 7'h6D, 7'h79}) begin n_fail++; $display("FAIL illegal_digits got %h exp %h", {d0, d1, d2, d3}, {7'h7E, 7'h30, 7'h6D, 7'h79}); end
      dwell(anode_of(2), C8, 16);
      dwell(anode_of(3), C8, 16);
      n_chk++; if (fd_cnt - f0 !== 0 || err_cnt - e0 !== 1) begin n_fail++; $display("FAIL illegal_hunt got fd=%0d err=%0d exp fd=0 err=1", fd_cnt - f0, err_cnt - e0); end
      n_chk++; if ({d2, d3} !== {7'h7F, 7'h7F}) begin n_fail++; $display("FAIL illegal_hunt_digits got %h exp %h", {d2, d3}, {7'h7F, 7'h7F}); end
      frame();
      n_chk++; if (sv !== 1'b1 || fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL illegal_recover got sv=%b fd=%0d exp sv=1 fd=1", sv, fd_cnt - f0); end
   endtask

   task automatic test_glitch();
      int f0, e0;
      f0 = fd_cnt; e0 = err_cnt;
      for (int k = 0; k < 8; k++) begin
         dwell(anode_of(0), ((k % 2) == 0) ? C8 : 7'b1111110, 2);
      end
      n_chk++; if (d0 !== 7'h7E) begin n_fail++; $display("FAIL glitch_no_capture got %h exp 7e", d0); end
      dwell(anode_of(0), 7'b0110000, 10);
      n_chk++; if (d0 !== 7'h4F) begin n_fail++; $display("FAIL glitch_capture got %h exp 4f", d0); end
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(2), C2, 16);
      dwell(anode_of(3), C3, 16);
      n_chk++; if (fd_cnt - f0 !== 1 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_order got fd=%0d err=%0d exp fd=1 err=0", fd_cnt - f0, err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      int f0, e0;
      f0 = fd_cnt; e0 = err_cnt;
      dwell(anode_of(0), C0, 16);
      dwell(anode_of(0), C1, 16);
      n_chk++; if (d0 !== 7'h30) begin n_fail++; $display("FAIL recapture_digit got %h exp 30", d0); end
      n_chk++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL recapture_err got %0d exp 0", err_cnt - e0); end
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(2), C2, 16);
      dwell(anode_of(3), C3, 16);
      n_chk++; if (fd_cnt - f0 !== 1 || sv !== 1'b1) begin n_fail++; $display("FAIL recapture_frame got fd=%0d sv=%b exp fd=1 sv=1", fd_cnt - f0, sv); end
   endtask

   task automatic test_reset_mid();
      int f0, e0;
      dwell(anode_of(0), C0, 16);
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(2), C8, 8);
      n_chk++; if (d2 !== 7'h7F) begin n_fail++; $display("FAIL mid_pre_reset got %h exp 7f", d2); end
      #2 rst = 1'b1;
      #1;
      n_chk++; if ({d0, d1, d2, d3} !== 28'h0) begin n_fail++; $display("FAIL mid_async_digits got %h exp 0", {d0, d1, d2, d3}); end
      n_chk++; if ({fd, se, sv} !== 3'b000) begin n_fail++; $display("FAIL mid_async_flags got %b exp 000", {fd, se, sv}); end
      @(negedge clk);
      rst = 1'b0;
      f0 = fd_cnt; e0 = err_cnt;
      dwell(anode_of(1), C1, 16);
      dwell(anode_of(2), C2, 16);
      dwell(anode_of(3), C3, 16);
      n_chk++; if (fd_cnt - f0 !== 0 || err_cnt - e0 !== 0 || sv !== 1'b0) begin n_fail++; $display("FAIL mid_no_frame got fd=%0d err=%0d sv=%b exp 0 0 0", fd_cnt - f0, err_cnt - e0, sv); end
      frame();
      n_chk++; if (fd_cnt - f0 !== 1 || sv !== 1'b1) begin n_fail++; $display("FAIL mid_frame got fd=%0d sv=%b exp fd=1 sv=1", fd_cnt - f0, sv); end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cnt;
      dwell(4'b1111, 7'h7F, 150);
      n_chk++; if (sv !== 1'b1) begin n_fail++; $display("FAIL timeout_early got %b exp 1", sv); end
      dwell(4'b1111, 7'h7F, 100);
      n_chk++; if (sv !== 1'b0) begin n_fail++; $display("FAIL timeout_valid got %b exp 0", sv); end
      n_chk++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL timeout_err got %0d exp 0", err_cnt - e0); end
      n_chk++; if ({d0, d1, d2, d3} !== {7'h7E, 7'h30, 7'h6D, 7'h79}) begin n_fail++; $display("FAIL timeout_hold got %h exp %h", {d0, d1, d2, d3}, {7'h7E, 7'h30, 7'h6D, 7'h79}); end
   endtask

   initial begin
      test_reset();
      test_clean_scan();
      test_out_of_order();
      test_illegal();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment drive. The block samples the active-low anode strobes and active-low cathode bus, then rebuilds the four digit patterns into registers. It checks scan order and reports frame completion, scan faults and loss of scan. It sits in the board self-test and bench path, monitoring the display pins the calculator drives.

Parameters:
SETTLE, 4, consecutive identical samples needed before a digit's cathodes are captured
TIMEOUT, 1000000, cycles without a capture before the scan is declared lost
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clock_100Mhz  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
Anode_Activate  input  4  monitored anode strobes, active-low, one-hot-low when a digit is on
LED_out  input  7  monitored cathodes, active-low, bit6=a … bit0=g
digit0  output  7  captured pattern, leftmost digit (anode 4'b0111), active-high segments
digit1  output  7  captured pattern, anode 4'b1011
digit2  output  7  captured pattern, anode 4'b1101
digit3  output  7  captured pattern, rightmost digit (anode 4'b1110)
frame_done  output  1  one-cycle pulse when digit3 is captured at the end of an in-order 0,1,2,3 sequence
scan_err  output  1  one-cycle pulse on an order fault or a multi-low anode
scan_valid  output  1  level; high after the first clean frame, low after an error or timeout

Behaviour:
- Reset (async, active-high): digit0..3=7'h00, frame_done=0, scan_err=0, scan_valid=0, state=HUNT, all counters=0, sync flops=all-ones.
- Input sync: Anode_Activate and LED_out each pass through 2 flops. All decisions use the synced values. Capture latency from a stable input to the digit register update is 2 + SETTLE cycles.
- Index decode: 0111→0, 1011→1, 1101→2, 1110→3.
  - 1111 = blank. It is legal, causes no error, and resets the stable counter.
  - Any pattern with two or more zeros = illegal. It produces a scan_err pulse, resets the stable counter and sends the FSM to HUNT.
- Stable counter: counts while the synced {anode, cathode} equal the previous cycle's value. Any change resets it to 0.
- Capture fires exactly once per dwell, on the cycle the counter reaches SETTLE-1. It does not re-fire until the inputs change.
- On capture: digit[idx] <= ~cathode (converted to active-high) and the timeout counter clears. A cathode change within the same anode dwell restarts settling and allows a second capture of the same idx. That recapture is not an order error.
- FSM:
  - HUNT: ignores captures with idx≠0 (digits are still updated, no error). A capture with idx=0 sets expect=1 and moves to TRACK.
  - TRACK: a capture with idx==expect sets expect=expect+1 mod 4. If idx==3, frame_done pulses, scan_valid←1 and expect=0. A capture with idx==previous idx is a recapture and is ignored for ordering. Any other idx pulses scan_err, clears scan_valid and goes to HUNT. If that idx was 0, it re-enters TRACK immediately with expect=1.
- Timeout: counter increments every cycle without a capture and saturates. On reaching TIMEOUT it clears scan_valid and goes to HUNT, with no scan_err. Digit registers hold their last values.
- Simultaneous events: an illegal anode takes priority over a capture. A timeout and a capture in the same cycle resolve as the capture (the counter clears).
- frame_done and scan_err are never both high in the same cycle.
- Reset mid-frame: immediate return to reset values. The next frame must start at idx 0.

Test Plan:
- Reset then idle (anode=1111): all digits 7'h00, scan_valid=0, no pulses; after TIMEOUT cycles still no scan_err.
- Clean scan 0→1→2→3, 16-cycle dwells, cathodes 7'b0000001,1001111,0010010,0000110: digit0..3=7'h7E,30,6D,79; frame_done pulses once 2+SETTLE cycles into the idx3 dwell; scan_valid rises on the same edge.
- Out of order 0→1→3 in TRACK: scan_err pulses once, scan_valid=0, digit3 still captured; the next 0,1,2,3 sequence restores scan_valid=1.
- Anode 4'b0011 for 8 cycles mid-frame: exactly one scan_err, FSM in HUNT; digits unchanged.
- Glitch: cathodes toggle every 2 cycles with SETTLE=4: no capture; then held 10 cycles: one capture.
- Assert reset during the idx2 dwell: outputs return to reset values asynchronously; after release, a sequence starting at idx1 produces no frame_done until idx0 is seen.
